// File: rtl/m1_wb_arbiter_if.sv
// Bundle of requester-side and Wishbone-side signals for the M1 arbiter.
// "master" is the arbiter's view (it masters the Wishbone bus); "slave" is
// the view of the surroundings (requesters plus the Wishbone slave).
interface m1_wb_arbiter_if #(
    parameter int N_CH = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SW   = DW / 8
);
    // requester side
    logic [N_CH-1:0]    req_i;
    logic [N_CH-1:0]    we_i;
    logic [N_CH*AW-1:0] addr_i;
    logic [N_CH*DW-1:0] data_i;
    logic [N_CH*SW-1:0] sel_i;
    logic [DW-1:0]      data_o;
    logic [N_CH-1:0]    done_o;
    logic [N_CH-1:0]    err_o;
    logic [N_CH-1:0]    grant_o;

    // Wishbone side
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [AW-1:0]      wb_adr_o;
    logic [DW-1:0]      wb_dat_o;
    logic [SW-1:0]      wb_sel_o;
    logic               wb_ack_i;
    logic [DW-1:0]      wb_dat_i;

    modport master (
        input  req_i, we_i, addr_i, data_i, sel_i, wb_ack_i, wb_dat_i,
        output data_o, done_o, err_o, grant_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output req_i, we_i, addr_i, data_i, sel_i, wb_ack_i, wb_dat_i,
        input  data_o, done_o, err_o, grant_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/m1_wb_arbiter.sv
// N-channel Wishbone master arbiter for the M1 core. Picks one requester
// (fixed priority or round-robin), runs a single classic Wishbone cycle for
// it, and returns a one-cycle done pulse (with err on bus timeout).
module m1_wb_arbiter #(
    parameter int N_CH    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            sys_clock_i,
    input  logic            sys_reset_n_i,
    m1_wb_arbiter_if.master bus
);
    localparam int            IDXW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDXW:0] N_CH_W  = (IDXW + 1)'(N_CH);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

    state_t          state_reg, state_next;
    logic [N_CH-1:0] grant_reg, grant_next;
    logic [IDXW-1:0] owner_reg, owner_next;
    // First channel examined by the round-robin search (one past last owner).
    logic [IDXW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic            cyc_reg, cyc_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   adr_reg, adr_next;
    logic [DW-1:0]   wdat_reg, wdat_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [DW-1:0]   rdata_reg, rdata_next;
    logic [N_CH-1:0] done_reg, done_next;
    logic [N_CH-1:0] err_reg, err_next;

    // Per-channel views of the flattened request buses.
    logic [AW-1:0] ch_addr [N_CH];
    logic [DW-1:0] ch_data [N_CH];
    logic [SW-1:0] ch_sel  [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_addr[gi] = bus.addr_i[gi*AW +: AW];
            assign ch_data[gi] = bus.data_i[gi*DW +: DW];
            assign ch_sel[gi]  = bus.sel_i[gi*SW +: SW];
        end
    endgenerate

    // Rotate requests so the search always starts at bit 0; fixed priority
    // is simply a rotation by zero.
    logic [IDXW-1:0]   search_base;
    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic              any_req;
    logic [IDXW:0]     wrap_sum;
    logic [IDXW-1:0]   win_idx;

    assign search_base = (RR_MODE != 0) ? rr_ptr_reg : '0;
    assign req_dbl     = {bus.req_i, bus.req_i} >> search_base;
    assign req_rot     = req_dbl[N_CH-1:0];
    assign any_req     = |bus.req_i;

    // Lowest set bit of the rotated vector, mapped back to a channel index.
    always_comb begin
        win_idx  = '0;
        wrap_sum = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                wrap_sum = {1'b0, search_base} + (IDXW + 1)'(i);
                if (wrap_sum >= N_CH_W) begin
                    wrap_sum = wrap_sum - N_CH_W;
                end
                win_idx = wrap_sum[IDXW-1:0];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUS/DONE sequence.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        tcnt_next   = tcnt_reg;
        cyc_next    = cyc_reg;
        we_next     = we_reg;
        adr_next    = adr_reg;
        wdat_next   = wdat_reg;
        sel_next    = sel_reg;
        rdata_next  = rdata_reg;
        done_next   = '0;
        err_next    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    owner_next          = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    adr_next            = ch_addr[win_idx];
                    wdat_next           = ch_data[win_idx];
                    sel_next            = ch_sel[win_idx];
                    we_next             = bus.we_i[win_idx];
                    cyc_next            = 1'b1;
                    tcnt_next           = '0;
                    state_next          = ST_BUS;
                end
            end
            ST_BUS: begin
                tcnt_next = tcnt_reg + TW'(1);
                // Ack is checked first so a last-moment ack beats the timeout.
                if (bus.wb_ack_i) begin
                    if (!we_reg) begin
                        rdata_next = bus.wb_dat_i;
                    end
                    cyc_next   = 1'b0;
                    done_next  = grant_reg;
                    state_next = ST_DONE;
                end else if ((TIMEOUT != 0) && (tcnt_reg == TO_LAST)) begin
                    cyc_next   = 1'b0;
                    done_next  = grant_reg;
                    err_next   = grant_reg;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_next  = '0;
                rr_ptr_next = (owner_reg == IDXW'(N_CH - 1)) ? '0 : owner_reg + IDXW'(1);
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
            tcnt_reg   <= '0;
            cyc_reg    <= 1'b0;
            we_reg     <= 1'b0;
            adr_reg    <= '0;
            wdat_reg   <= '0;
            sel_reg    <= '0;
            rdata_reg  <= '0;
            done_reg   <= '0;
            err_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            tcnt_reg   <= tcnt_next;
            cyc_reg    <= cyc_next;
            we_reg     <= we_next;
            adr_reg    <= adr_next;
            wdat_reg   <= wdat_next;
            sel_reg    <= sel_next;
            rdata_reg  <= rdata_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign bus.grant_o  = grant_reg;
    assign bus.done_o   = done_reg;
    assign bus.err_o    = err_reg;
    assign bus.data_o   = rdata_reg;
    assign bus.wb_cyc_o = cyc_reg;
    assign bus.wb_stb_o = cyc_reg;
    assign bus.wb_we_o  = we_reg;
    assign bus.wb_adr_o = adr_reg;
    assign bus.wb_dat_o = wdat_reg;
    assign bus.wb_sel_o = sel_reg;
endmodule

// File: tb/tb_m1_wb_arbiter.sv
// Bench for m1_wb_arbiter: two instances (2-ch fixed priority, 4-ch
// round-robin, both TIMEOUT=4) checked every cycle against a transaction
// model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_m1_wb_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 4;
    localparam int NCFG = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus, unified to 4 channels per configuration
    logic [3:0]  s_req  [NCFG];
    logic [3:0]  s_we   [NCFG];
    logic [31:0] s_addr [NCFG][4];
    logic [31:0] s_wr   [NCFG][4];
    logic [3:0]  s_sel  [NCFG][4];
    logic        s_ack  [NCFG];
    logic [31:0] s_rdat [NCFG];

    // observed outputs
    logic        o_cyc [NCFG], o_stb [NCFG], o_we [NCFG];
    logic [31:0] o_adr [NCFG], o_wdat [NCFG], o_data [NCFG];
    logic [3:0]  o_sel [NCFG], o_done [NCFG], o_err [NCFG], o_grant [NCFG];

    m1_wb_arbiter_if #(.N_CH(2), .AW(AW), .DW(DW)) bus_a ();
    m1_wb_arbiter_if #(.N_CH(4), .AW(AW), .DW(DW)) bus_b ();

    m1_wb_arbiter #(.N_CH(2), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO), .TW(8)) dut_a (
        .sys_clock_i(clk), .sys_reset_n_i(rst_n), .bus(bus_a));
    m1_wb_arbiter #(.N_CH(4), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO), .TW(8)) dut_b (
        .sys_clock_i(clk), .sys_reset_n_i(rst_n), .bus(bus_b));

    assign bus_a.req_i    = s_req[0][1:0];
    assign bus_a.we_i     = s_we[0][1:0];
    assign bus_a.wb_ack_i = s_ack[0];
    assign bus_a.wb_dat_i = s_rdat[0];
    assign bus_b.req_i    = s_req[1];
    assign bus_b.we_i     = s_we[1];
    assign bus_b.wb_ack_i = s_ack[1];
    assign bus_b.wb_dat_i = s_rdat[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_a
            assign bus_a.addr_i[gi*AW +: AW] = s_addr[0][gi];
            assign bus_a.data_i[gi*DW +: DW] = s_wr[0][gi];
            assign bus_a.sel_i[gi*4 +: 4]    = s_sel[0][gi];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_b
            assign bus_b.addr_i[gi*AW +: AW] = s_addr[1][gi];
            assign bus_b.data_i[gi*DW +: DW] = s_wr[1][gi];
            assign bus_b.sel_i[gi*4 +: 4]    = s_sel[1][gi];
        end
    endgenerate

    assign o_cyc[0] = bus_a.wb_cyc_o;   assign o_cyc[1] = bus_b.wb_cyc_o;
    assign o_stb[0] = bus_a.wb_stb_o;   assign o_stb[1] = bus_b.wb_stb_o;
    assign o_we[0]  = bus_a.wb_we_o;    assign o_we[1]  = bus_b.wb_we_o;
    assign o_adr[0] = bus_a.wb_adr_o;   assign o_adr[1] = bus_b.wb_adr_o;
    assign o_wdat[0] = bus_a.wb_dat_o;  assign o_wdat[1] = bus_b.wb_dat_o;
    assign o_sel[0] = bus_a.wb_sel_o;   assign o_sel[1] = bus_b.wb_sel_o;
    assign o_data[0] = bus_a.data_o;    assign o_data[1] = bus_b.data_o;
    assign o_done[0] = {2'b00, bus_a.done_o};   assign o_done[1] = bus_b.done_o;
    assign o_err[0]  = {2'b00, bus_a.err_o};    assign o_err[1]  = bus_b.err_o;
    assign o_grant[0] = {2'b00, bus_a.grant_o}; assign o_grant[1] = bus_b.grant_o;

    // ---------------- transaction model ----------------
    // m_phase: 0 = no transaction, 1 = on the bus, 2 = completion cycle
    int          m_phase [NCFG];
    int          m_owner [NCFG];
    int          m_start [NCFG];   // round-robin search start
    int          m_wait  [NCFG];   // bus cycles already spent without ack
    logic        e_cyc   [NCFG], e_we [NCFG];
    logic [31:0] e_adr   [NCFG], e_wdat [NCFG], e_data [NCFG];
    logic [3:0]  e_sel   [NCFG], e_done [NCFG], e_err [NCFG], e_grant [NCFG];

    function automatic int nch(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    function automatic int pick(input int c, input logic [3:0] req);
        int n;
        int start;
        int k;
        n = nch(c);
        start = (c == 1) ? m_start[c] : 0;
        for (int i = 0; i < n; i++) begin
            k = (start + i) % n;
            if (((req >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    task automatic model_reset(input int c);
        m_phase[c] = 0; m_owner[c] = 0; m_start[c] = 0; m_wait[c] = 0;
        e_cyc[c] = 1'b0; e_we[c] = 1'b0; e_adr[c] = '0; e_wdat[c] = '0;
        e_data[c] = '0; e_sel[c] = '0; e_done[c] = '0; e_err[c] = '0; e_grant[c] = '0;
    endtask

    task automatic model_step(input int c);
        logic [3:0] mask;
        logic [3:0] d;
        logic [3:0] er;
        int g;
        mask = (c == 0) ? 4'h3 : 4'hF;
        d = '0;
        er = '0;
        if (m_phase[c] == 0) begin
            g = pick(c, s_req[c] & mask);
            if (g >= 0) begin
                m_owner[c] = g;
                e_grant[c] = 4'(1 << g);
                e_adr[c]   = s_addr[c][g];
                e_wdat[c]  = s_wr[c][g];
                e_sel[c]   = s_sel[c][g];
                e_we[c]    = s_we[c][g];
                e_cyc[c]   = 1'b1;
                m_wait[c]  = 0;
                m_phase[c] = 1;
            end
        end else if (m_phase[c] == 1) begin
            if (s_ack[c]) begin
                if (!e_we[c]) e_data[c] = s_rdat[c];
                e_cyc[c] = 1'b0;
                d = e_grant[c];
                m_phase[c] = 2;
            end else if (m_wait[c] + 1 == TO) begin
                e_cyc[c] = 1'b0;
                d  = e_grant[c];
                er = e_grant[c];
                m_phase[c] = 2;
            end else begin
                m_wait[c] = m_wait[c] + 1;
            end
        end else begin
            m_start[c] = (m_owner[c] + 1) % nch(c);
            e_grant[c] = '0;
            m_phase[c] = 0;
        end
        e_done[c] = d;
        e_err[c]  = er;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d @%0t: got 0x%08h, expected 0x%08h", name, c, $time, act, exp);
        end
    endtask

    task automatic compare_all(input int c);
        check("cyc",    c, 32'(o_cyc[c]),   32'(e_cyc[c]));
        check("stb",    c, 32'(o_stb[c]),   32'(e_cyc[c]));
        check("we",     c, 32'(o_we[c]),    32'(e_we[c]));
        check("adr",    c, o_adr[c],        e_adr[c]);
        check("wdat",   c, o_wdat[c],       e_wdat[c]);
        check("sel",    c, 32'(o_sel[c]),   32'(e_sel[c]));
        check("data_o", c, o_data[c],       e_data[c]);
        check("done",   c, 32'(o_done[c]),  32'(e_done[c]));
        check("err",    c, 32'(o_err[c]),   32'(e_err[c]));
        check("grant",  c, 32'(o_grant[c]), 32'(e_grant[c]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int c = 0; c < NCFG; c++) model_step(c);
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            compare_all(c);
            if (e_done[c] != 4'd0)
                $display("[TB] cfg%0d txn grant=%b err=%b we=%0d adr=%08h data_o=%08h",
                         c, e_grant[c], e_err[c], e_we[c], e_adr[c], e_data[c]);
        end
    endtask

    task automatic idle_inputs();
        for (int c = 0; c < NCFG; c++) begin
            s_req[c] = '0; s_we[c] = '0; s_ack[c] = 1'b0; s_rdat[c] = '0;
            for (int k = 0; k < 4; k++) begin
                s_addr[c][k] = '0; s_wr[c][k] = '0; s_sel[c][k] = '0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          order_a[$];
    int          order_b[$];
    logic [3:0]  prev_g [NCFG];

    initial begin
        idle_inputs();
        for (int c = 0; c < NCFG; c++) model_reset(c);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            compare_all(c);
            check("rst_cyc", c, 32'(o_cyc[c]), 32'd0);
        end
        rst_n = 1'b1;

        // single read on cfg0, channel 0
        s_req[0] = 4'b0001; s_addr[0][0] = 32'h0000_1000;
        cycle();
        check("rd_cyc_up", 0, 32'(o_cyc[0]), 32'd1);
        check("rd_adr", 0, o_adr[0], 32'h0000_1000);
        check("rd_grant", 0, 32'(o_grant[0]), 32'd1);
        s_ack[0] = 1'b1; s_rdat[0] = 32'hDEAD_BEEF;
        cycle();
        check("rd_done", 0, 32'(o_done[0]), 32'd1);
        check("rd_data", 0, o_data[0], 32'hDEAD_BEEF);
        check("rd_err", 0, 32'(o_err[0]), 32'd0);
        s_req[0] = '0; s_ack[0] = 1'b0;
        cycle();
        check("rd_done_pulse", 0, 32'(o_done[0]), 32'd0);
        check("rd_grant_clr", 0, 32'(o_grant[0]), 32'd0);

        // write with byte selects on cfg0, channel 1
        s_req[0] = 4'b0010; s_we[0] = 4'b0010; s_addr[0][1] = 32'h20;
        s_wr[0][1] = 32'h1234_5678; s_sel[0][1] = 4'b0011; s_rdat[0] = 32'hCAFE_F00D;
        cycle();
        check("wr_we", 0, 32'(o_we[0]), 32'd1);
        check("wr_sel", 0, 32'(o_sel[0]), 32'd3);
        check("wr_dat", 0, o_wdat[0], 32'h1234_5678);
        s_ack[0] = 1'b1;
        cycle();
        check("wr_done", 0, 32'(o_done[0]), 32'd2);
        check("wr_data_hold", 0, o_data[0], 32'hDEAD_BEEF);
        s_req[0] = '0; s_we[0] = '0; s_ack[0] = 1'b0;
        cycle();

        // timeout: no ack for four bus cycles
        s_req[0] = 4'b0001; s_rdat[0] = 32'h5555_5555;
        cycle();
        repeat (3) cycle();
        check("to_cyc_held", 0, 32'(o_cyc[0]), 32'd1);
        cycle();
        check("to_cyc_drop", 0, 32'(o_cyc[0]), 32'd0);
        check("to_done", 0, 32'(o_done[0]), 32'd1);
        check("to_err", 0, 32'(o_err[0]), 32'd1);
        check("to_data_hold", 0, o_data[0], 32'hDEAD_BEEF);
        s_req[0] = '0;
        cycle();

        // ack in the fourth bus cycle beats the timeout
        s_req[0] = 4'b0001; s_rdat[0] = 32'hA5A5_0004;
        cycle();
        repeat (3) cycle();
        s_ack[0] = 1'b1;
        cycle();
        check("late_done", 0, 32'(o_done[0]), 32'd1);
        check("late_err", 0, 32'(o_err[0]), 32'd0);
        check("late_data", 0, o_data[0], 32'hA5A5_0004);
        s_req[0] = '0; s_ack[0] = 1'b0;
        cycle();

        // fixed priority on cfg0, round-robin with re-raised requests on cfg1
        s_req[0] = 4'b0011; s_addr[0][0] = 32'h100; s_addr[0][1] = 32'h200;
        s_req[1] = 4'hF;
        for (int k = 0; k < 4; k++) s_addr[1][k] = 32'h1000 * (k + 1);
        s_ack[0] = 1'b1; s_ack[1] = 1'b1;
        prev_g[0] = '0; prev_g[1] = '0;
        for (int t = 0; t < 16; t++) begin
            cycle();
            if (o_grant[0] != 4'd0 && prev_g[0] == 4'd0) order_a.push_back(int'(o_grant[0]));
            if (o_grant[1] != 4'd0 && prev_g[1] == 4'd0) order_b.push_back(int'(o_grant[1]));
            prev_g[0] = o_grant[0]; prev_g[1] = o_grant[1];
            s_req[0] = s_req[0] & ~e_done[0];
            s_req[1] = (e_done[1] != 4'd0) ? (4'hF & ~e_done[1]) : 4'hF;
        end
        check("prio_count", 0, 32'(order_a.size()), 32'd2);
        if (order_a.size() >= 2) begin
            check("prio_first", 0, 32'(order_a[0]), 32'd1);
            check("prio_second", 0, 32'(order_a[1]), 32'd2);
        end
        check("rr_count", 1, 32'(order_b.size() >= 5), 32'd1);
        if (order_b.size() >= 5) begin
            check("rr_g0", 1, 32'(order_b[0]), 32'd1);
            check("rr_g1", 1, 32'(order_b[1]), 32'd2);
            check("rr_g2", 1, 32'(order_b[2]), 32'd4);
            check("rr_g3", 1, 32'(order_b[3]), 32'd8);
            check("rr_wrap", 1, 32'(order_b[4]), 32'd1);
        end
        s_req[0] = '0; s_req[1] = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
        repeat (8) cycle();

        // asynchronous reset in the middle of a bus cycle
        s_req[0] = 4'b0001; s_req[1] = 4'b0100;
        cycle();
        check("rst_pre_cyc_a", 0, 32'(o_cyc[0]), 32'd1);
        check("rst_pre_cyc_b", 1, 32'(o_cyc[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCFG; c++) begin
            check("arst_cyc", c, 32'(o_cyc[c]), 32'd0);
            check("arst_grant", c, 32'(o_grant[c]), 32'd0);
            check("arst_done", c, 32'(o_done[c]), 32'd0);
            model_reset(c);
        end
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) compare_all(c);
        rst_n = 1'b1;
        cycle();
        s_ack[0] = 1'b1; s_ack[1] = 1'b1;
        cycle();
        check("post_rst_done_a", 0, 32'(o_done[0]), 32'd1);
        check("post_rst_done_b", 1, 32'(o_done[1]), 32'd4);
        s_req[0] = '0; s_req[1] = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
        cycle();

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < NCFG; c++) begin
                for (int k = 0; k < nch(c); k++) begin
                    if (e_done[c][k]) begin
                        s_req[c][k] = 1'b0;
                    end else if (!s_req[c][k] && ($urandom % 3 == 0)) begin
                        s_req[c][k] = 1'b1;
                    end else if (s_req[c][k] && ($urandom % 50 == 0)) begin
                        s_req[c][k] = 1'b0;
                    end
                    if ($urandom % 2 == 0) begin
                        s_we[c][k]   = 1'($urandom);
                        s_addr[c][k] = $urandom;
                        s_wr[c][k]   = $urandom;
                        s_sel[c][k]  = 4'($urandom);
                    end
                end
                s_ack[c]  = ($urandom % 4 == 0);
                s_rdat[c] = $urandom;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/m1_wb_arbiter.md
Name: m1_wb_arbiter

Overview:
Parametrised N-channel Wishbone master arbiter that replaces the fixed two-port instruction/data memory front end of the M1 core. Each channel uses the core's memory request/done handshake. The block arbitrates between channels with fixed-priority or round-robin selection and issues one classic Wishbone cycle at a time. A bus timeout reports an error to the requester instead of hanging the core.

Parameters:
N_CH, 2, number of requester channels (2..8); channel 0 = instruction fetch, channel 1 = data
AW, 32, address width
DW, 32, data width (multiple of 8)
SW, DW/8, byte-select width (derived)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 255, max cycles waiting for wb_ack_i; 0 = timeout disabled
TW, 8, timeout counter width (must hold TIMEOUT)

Ports:
sys_clock_i  in  1  system clock, rising edge
sys_reset_n_i  in  1  reset, asynchronous assert, active-low
req_i  in  N_CH  per-channel request; held high until done_o
we_i  in  N_CH  per-channel write enable
addr_i  in  N_CH*AW  per-channel address, channel k at [k*AW +: AW]
data_i  in  N_CH*DW  per-channel write data
sel_i  in  N_CH*SW  per-channel byte selects
data_o  out  DW  read data, shared by all channels, valid with done_o
done_o  out  N_CH  one-cycle completion pulse for the granted channel
err_o  out  N_CH  one-cycle error pulse, coincident with done_o, on timeout
grant_o  out  N_CH  one-hot owner of the current transaction; 0 when idle
wb_cyc_o  out  1  WB cycle
wb_stb_o  out  1  WB strobe (always equal to wb_cyc_o)
wb_we_o  out  1  WB write enable
wb_adr_o  out  AW  WB address
wb_dat_o  out  DW  WB write data
wb_sel_o  out  SW  WB byte select
wb_ack_i  in  1  WB acknowledge
wb_dat_i  in  DW  WB read data

Behaviour:
- Reset (async, sys_reset_n_i=0): every output 0; FSM=IDLE; round-robin pointer=0; timeout counter=0. Reset applied mid-transaction drops wb_cyc_o/wb_stb_o immediately; no done_o is issued.
- FSM states: IDLE, BUS, DONE.
- IDLE: if any req_i bit is set, pick winner g.
  - RR_MODE=0: lowest set index wins.
  - RR_MODE=1: first set index searching upward from (last_grant+1) mod N_CH.
  - Register grant_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o from channel g; assert wb_cyc_o and wb_stb_o; clear the timeout counter; go to BUS. Bus signals are visible the cycle after req_i is sampled.
- BUS: wb_* outputs are held stable and the timeout counter increments each cycle.
  - On wb_ack_i=1: capture wb_dat_i into data_o for reads (data_o is unchanged on writes); drop wb_cyc_o/wb_stb_o; go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: drop wb_cyc_o/wb_stb_o; set the error flag; go to DONE.
  - If ack and timeout expiry fall in the same cycle, ack wins and no error is raised.
- DONE: exactly one cycle. done_o[g]=1; err_o[g]=1 if the error flag is set. Update last_grant=g; clear grant_o and the error flag; go to IDLE. A requester must drop req_i on the edge where it sees done_o.
- Throughput: zero-wait ack gives 3 cycles per transaction (IDLE, BUS, DONE). wb_cyc_o is low for at least 2 cycles between transactions.
- A channel that drops req_i during BUS does not abort the cycle; it completes and done_o still pulses.
- req_i, we_i, addr_i, data_i and sel_i of non-granted channels are ignored outside IDLE.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o keep their last values when wb_cyc_o=0.
- data_o keeps its value until the next read completes. On a timed-out read, data_o is not updated.
- Round-robin pointer wrap-around: after last_grant=N_CH-1, the search starts at channel 0.

Test Plan:
- Single read, N_CH=2: req_i=01, addr ch0=0x0000_1000, ack one cycle after stb, wb_dat_i=0xDEAD_BEEF -> cyc/stb high 1 cycle after req; done_o=01 for one cycle; data_o=0xDEAD_BEEF; err_o=0.
- Fixed priority, RR_MODE=0: req_i=11 held, each channel dropping req on its done -> ch0 served first, then ch1; wb_adr_o matches each channel's addr; never two grants at once.
- Round-robin, N_CH=4, RR_MODE=1: req_i=1111 held continuously, requests re-raised after each done -> grant order 0,1,2,3,0; wrap-around verified.
- Write with sel: ch1 we=1, addr=0x20, data=0x1234_5678, sel=0011 -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x1234_5678; done_o=10; data_o unchanged.
- Timeout, TIMEOUT=4: no ack -> cyc drops after 4 BUS cycles; done_o and err_o pulse together for the granted channel. Repeat with ack in the 4th cycle -> err_o=0.
- Async reset mid-BUS: pull sys_reset_n_i low between clock edges -> wb_cyc_o, grant_o and done_o go to 0 immediately; after release, a fresh request completes normally.
